// File: rtl/debounce_pkg.sv
// Shared types for the debounce / edge-strobe block.
package debounce_pkg;

   // STABLE: q agrees with the synchronized input.
   // WAIT:   the input disagrees with q and the disagreement is being timed.
   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_WAIT   = 1'b1
   } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronizes a noisy input, accepts a new level only after it has
// been seen for STABLE_CYCLES consecutive synchronized samples, and emits a
// one-cycle rise/fall strobe in the same cycle the debounced level changes.
//
// Handshake note: there is no valid/ready pairing here. rise and fall are
// single-cycle qualifiers that are valid exactly in the cycle q has just
// taken its new value; downstream logic samples them every cycle.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
   // Count value at which the next mismatching sample completes the window.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s;
   db_state_t        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             q_q;
   logic             rise_q;
   logic             fall_q;

   sync_2ff #(
      .RESET_VAL(RESET_LEVEL)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (din),
      .q  (s)
   );

   // Incremented count; only used while timing a mismatch, so it cannot
   // pass CNT_LAST.
   assign cnt_d = cnt_q + 1'b1;

   // Stability FSM with the counter and registered level/strobe outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         q_q     <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            ST_STABLE: begin
               if (s != q_q) begin
                  // This sample is the first of the window.
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_W'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            ST_WAIT: begin
               if (s == q_q) begin
                  // Bounce back: drop the pending change silently.
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  q_q     <= s;
                  rise_q  <= s;
                  fall_q  <= ~s;
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            default: begin
               state_q <= ST_STABLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: a STABLE_CYCLES=4 instance and a STABLE_CYCLES=2
// instance share stimulus; a sample-window reference model tracks both.
module tb_debounce_edge;
   import debounce_pkg::*;

   // ---------------- clock / reset / DUTs ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic q4, rise4, fall4;
   logic q2, rise2, fall2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debounce_edge #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut4 (
      .clk(clk), .rst(rst), .din(din), .q(q4), .rise(rise4), .fall(fall4)
   );

   debounce_edge #(.STABLE_CYCLES(2), .RESET_LEVEL(1'b0)) dut2 (
      .clk(clk), .rst(rst), .din(din), .q(q2), .rise(rise2), .fall(fall2)
   );

   // ---------------- reference model ----------------
   // din reaches the decision logic two samples late; a new level is taken
   // once it has been observed on N consecutive samples in a row.
   logic hist1 [2];
   logic hist2 [2];
   logic m_q   [2];
   logic m_rise[2];
   logic m_fall[2];
   int   m_seen[2];

   task automatic model_edge(input int k, input int n, input logic r, input logic d);
      logic s;
      if (r) begin
         hist1[k] = 1'b0; hist2[k] = 1'b0; m_q[k] = 1'b0;
         m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_seen[k] = 0;
      end else begin
         s = hist2[k];
         hist2[k] = hist1[k];
         hist1[k] = d;
         m_rise[k] = 1'b0;
         m_fall[k] = 1'b0;
         m_seen[k] = (s != m_q[k]) ? m_seen[k] + 1 : 0;
         if (m_seen[k] == n) begin
            m_rise[k] = s;
            m_fall[k] = ~s;
            m_q[k]    = s;
            m_seen[k] = 0;
         end
      end
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: inputs were set before the edge; model follows the edge;
   // outputs are compared 1ns later.
   task automatic step();
      @(posedge clk);
      model_edge(0, 4, rst, din);
      model_edge(1, 2, rst, din);
      #1;
   endtask

   task automatic chk_model();
      chk("m4_q",    q4,    m_q[0]);
      chk("m4_rise", rise4, m_rise[0]);
      chk("m4_fall", fall4, m_fall[0]);
      chk("m2_q",    q2,    m_q[1]);
      chk("m2_rise", rise2, m_rise[1]);
      chk("m2_fall", fall2, m_fall[1]);
   endtask

   // which: 0 = rise4, 1 = fall4, 2 = rise2. Reports edges after the first
   // edge that samples the current din (that edge counts as 0).
   task automatic wait_strobe(input string name, input int which, input int exp_edges);
      int got;
      logic hit;
      got = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         hit = (which == 0) ? rise4 : (which == 1) ? fall4 : rise2;
         if (hit === 1'b1) begin
            got = i;
            break;
         end
      end
      chk(name, got, exp_edges);
   endtask

   // Strobes must never overlap nor appear on consecutive cycles.
   logic mon_en = 1'b0;
   logic prev4  = 1'b0;
   logic prev2  = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((rise4 & fall4) | (rise2 & fall2)) begin
            errors++;
            $display("FAIL strobe_overlap: rise4=%0b fall4=%0b rise2=%0b fall2=%0b required no overlap", rise4, fall4, rise2, fall2);
         end
         checks++;
         if (((rise4 | fall4) & prev4) | ((rise2 | fall2) & prev2)) begin
            errors++;
            $display("FAIL strobe_back_to_back: strobe in two consecutive cycles at %0t", $time);
         end
         prev4 = rise4 | fall4;
         prev2 = rise2 | fall2;
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic r;
      logic d;
      logic eq;
      logic er;
      logic ef;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic d, input logic eq, input logic er, input logic ef);
      vec_t v;
      v.r = r; v.d = d; v.eq = eq; v.er = er; v.ef = ef;
      tbl.push_back(v);
   endfunction

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : main
      int strobes;
      int qchg;
      int run_left;
      logic lvl;

      // reset held 3 cycles with din high: q and strobes stay low
      repeat (3) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // clean 0->1: E0 is the first row with din=1; rise lands 5 edges later
      repeat (5) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      // clean 1->0: fall 5 edges after E0, exactly one cycle wide
      repeat (5) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].r;
         din = tbl[i].d;
         step();
         chk($sformatf("vec%0d_q", i),    q4,    tbl[i].eq);
         chk($sformatf("vec%0d_rise", i), rise4, tbl[i].er);
         chk($sformatf("vec%0d_fall", i), fall4, tbl[i].ef);
         if (i == 0) mon_en = 1'b1;
         if (i == 3) chk("state_after_reset", 32'(dut4.state_q), 32'(ST_STABLE));
      end

      // short 3-sample pulse is ignored; the retry is accepted
      strobes = 0;
      din = 1'b1;
      repeat (3) begin step(); strobes += int'(rise4 | fall4); end
      din = 1'b0;
      repeat (6) begin step(); strobes += int'(rise4 | fall4); end
      chk("bounce_no_strobe", strobes, 0);
      chk("bounce_q_held", q4, 1'b0);
      din = 1'b1;
      wait_strobe("bounce_retry_rise", 0, 5);
      chk("bounce_retry_q", q4, 1'b1);

      // reset during WAIT discards the pending change
      rst = 1'b1; din = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
      din = 1'b1;
      strobes = 0;
      repeat (4) begin step(); strobes += int'(rise4 | fall4); end
      chk("midwait_state", 32'(dut4.state_q), 32'(ST_WAIT));
      rst = 1'b1;
      step();
      strobes += int'(rise4 | fall4);
      chk("midwait_no_strobe", strobes, 0);
      chk("midwait_q", q4, 1'b0);
      chk("midwait_state_reset", 32'(dut4.state_q), 32'(ST_STABLE));
      rst = 1'b0;
      wait_strobe("midwait_release_rise", 0, 5);

      // STABLE_CYCLES=2: per-cycle toggling never settles
      rst = 1'b1;
      step();
      rst = 1'b0;
      strobes = 0;
      qchg = 0;
      for (int i = 0; i < 20; i++) begin
         din = ~i[0];
         step();
         strobes += int'(rise2 | fall2);
         if (q2 !== 1'b0) qchg++;
      end
      chk("toggle2_no_strobe", strobes, 0);
      chk("toggle2_q_const", qchg, 0);
      din = 1'b1;
      wait_strobe("toggle2_hold_rise", 2, 3);
      chk("toggle2_hold_q", q2, 1'b1);

      // randomized bouncing runs with occasional resets, against the model
      rst = 1'b1;
      step();
      rst = 1'b0;
      run_left = 0;
      lvl = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (run_left == 0) begin
            lvl = 1'($urandom_range(0, 1));
            run_left = $urandom_range(1, 7);
         end
         run_left--;
         din = lvl;
         rst = ($urandom_range(0, 149) == 0);
         step();
         chk_model();
      end
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
